// File: rtl/addressing_threshold_writer.sv
// addressing_threshold_writer: captures one camera frame as four thresholded bit-planes with a counter-based write address.
// Define THRESH_LATCH_EN to freeze the thresholds at the SOF that starts or restarts a frame.
module addressing_threshold_writer (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        arm_in,
  input  logic        continuous_in,
  input  logic        pixel_valid_in,
  input  logic [8:0]  hcount_in,
  input  logic [7:0]  vcount_in,
  input  logic [7:0]  pixel_in,
  input  logic [7:0]  thresh_1_in,
  input  logic [7:0]  thresh_2_in,
  input  logic [7:0]  thresh_3_in,
  input  logic [7:0]  thresh_4_in,
  output logic        we_out,
  output logic [16:0] addr_out,
  output logic [3:0]  data_out,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic        resync_err_out
);
  typedef enum logic [1:0] {IDLE, WAIT_SOF, WRITE, DONE} state_t;
  localparam logic [16:0] LAST_ADDR = 17'd76799;
  state_t state_q, state_d;
  logic [16:0] cnt_q, cnt_d, addr_q, addr_d, wr_addr;
  logic [3:0] data_q, data_d;
  logic we_q, we_d, resync_q, resync_d, sof, accept, start;
  logic [31:0] thr_live, thr_use;
  assign thr_live = {thresh_4_in, thresh_3_in, thresh_2_in, thresh_1_in};
`ifdef THRESH_LATCH_EN
  logic [31:0] thr_q, thr_d;
  // the SOF pixel itself must see the thresholds being latched on that edge
  assign thr_d = start ? thr_live : thr_q;
  assign thr_use = thr_d;
  always_ff @(posedge clk_in) thr_q <= rst_in ? '0 : thr_d;
`else
  assign thr_use = thr_live;
`endif
  always_comb begin
    sof = pixel_valid_in && hcount_in == '0 && vcount_in == '0;
    accept = (state_q == WAIT_SOF && sof) || (state_q == WRITE && pixel_valid_in);
    start = accept && sof;
    wr_addr = start ? '0 : cnt_q;
    we_d = accept;
    addr_d = accept ? wr_addr : addr_q;
    data_d = data_q;
    for (int k = 0; k < 4; k++)
      if (accept) data_d[k] = pixel_in >= thr_use[8*k +: 8];
    cnt_d = accept ? wr_addr + 17'd1 : cnt_q;
    resync_d = resync_q || (state_q == WRITE && sof && cnt_q != '0);
    state_d = state_q;
    case (state_q)
      IDLE: if (arm_in) begin
        state_d = WAIT_SOF;
        resync_d = 1'b0;
      end
      WAIT_SOF: state_d = sof ? WRITE : WAIT_SOF;
      WRITE: state_d = (accept && wr_addr == LAST_ADDR) ? DONE : WRITE;
      DONE: begin
        state_d = continuous_in ? WAIT_SOF : IDLE;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q <= we_d;
      resync_q <= resync_d;
    end
  end
  assign we_out = we_q;
  assign addr_out = addr_q;
  assign data_out = data_q;
  assign busy_out = state_q == WAIT_SOF || state_q == WRITE;
  assign frame_done_out = state_q == DONE;
  assign resync_err_out = resync_q;
endmodule

// File: tb/tb_addressing_threshold_writer.sv
// tb_addressing_threshold_writer: directed scenarios with hand-derived expected outputs.
module tb_addressing_threshold_writer;
  logic clk_in = 1'b0, rst_in, arm_in, continuous_in, pixel_valid_in;
  logic [8:0] hcount_in;
  logic [7:0] vcount_in, pixel_in, thresh_1_in, thresh_2_in, thresh_3_in, thresh_4_in;
  logic we_out, busy_out, frame_done_out, resync_err_out;
  logic [16:0] addr_out;
  logic [3:0] data_out;
  int n_checks = 0, n_fail = 0;
`ifdef THRESH_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  addressing_threshold_writer dut (
    .clk_in(clk_in), .rst_in(rst_in), .arm_in(arm_in), .continuous_in(continuous_in),
    .pixel_valid_in(pixel_valid_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .pixel_in(pixel_in), .thresh_1_in(thresh_1_in), .thresh_2_in(thresh_2_in),
    .thresh_3_in(thresh_3_in), .thresh_4_in(thresh_4_in), .we_out(we_out),
    .addr_out(addr_out), .data_out(data_out), .busy_out(busy_out),
    .frame_done_out(frame_done_out), .resync_err_out(resync_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic pix(input int i, input logic [7:0] p);
    pixel_valid_in = 1'b1;
    hcount_in = 9'(i % 320);
    vcount_in = 8'(i / 320);
    pixel_in = p;
  endtask

  task automatic arm;
    arm_in = 1'b1;
    tick;
    arm_in = 1'b0;
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    tick;
    tick;
    n_checks++; if (we_out !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0h want 0", we_out); end
    n_checks++; if (addr_out !== 17'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", addr_out); end
    n_checks++; if (data_out !== 4'd0) begin n_fail++; $display("FAIL reset_data got %0h want 0", data_out); end
    n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0h want 0", busy_out); end
    n_checks++; if (frame_done_out !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0h want 0", frame_done_out); end
    n_checks++; if (resync_err_out !== 1'b0) begin n_fail++; $display("FAIL reset_resync got %0h want 0", resync_err_out); end
    rst_in = 1'b0;
    pix(0, 8'd200);
    tick;
    n_checks++; if (we_out !== 1'b0 || busy_out !== 1'b0) begin n_fail++; $display("FAIL idle_sof_ignored got we=%0h busy=%0h want 0 0", we_out, busy_out); end
    pixel_valid_in = 1'b0;
  endtask

  task automatic test_valid_gaps;
    int idx = 0;
    thresh_1_in = 8'd0; thresh_2_in = 8'd100; thresh_3_in = 8'd128; thresh_4_in = 8'd200;
    arm;
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) pix(idx, 8'd128);
      else begin pixel_valid_in = 1'b0; hcount_in = '0; vcount_in = '0; end
      tick;
      n_checks++; if (we_out !== (c % 2 == 0)) begin n_fail++; $display("FAIL gap_we c=%0d got %0h want %0h", c, we_out, c % 2 == 0); end
      if (c % 2 == 0) begin
        n_checks++; if (addr_out !== 17'(idx) || data_out !== 4'b0111) begin n_fail++; $display("FAIL gap_addr got %0d/%0h want %0d/7", addr_out, data_out, idx); end
        idx++;
      end
    end
    pixel_valid_in = 1'b0;
    rst_in = 1'b1;
    tick;
    rst_in = 1'b0;
  endtask

  task automatic test_frame_resync_continuous;
    int ae = 0, de = 0, dc = 0, wc = 0;
    logic [16:0] da = '0;
    logic [3:0] ed;
    thresh_1_in = 8'd0; thresh_2_in = 8'd100; thresh_3_in = 8'd128; thresh_4_in = 8'd200;
    continuous_in = 1'b1;
    arm;
    pix(5, 8'd128);
    tick;
    n_checks++; if (we_out !== 1'b0 || busy_out !== 1'b1) begin n_fail++; $display("FAIL wait_sof_non_sof got we=%0h busy=%0h want 0 1", we_out, busy_out); end
    for (int i = 0; i < 500; i++) begin
      pix(i, 8'd128);
      tick;
      if (we_out !== 1'b1 || addr_out !== 17'(i)) ae++;
      if (data_out !== 4'b0111) de++;
    end
    n_checks++; if (ae !== 0 || de !== 0) begin n_fail++; $display("FAIL pre_resync_errs got addr=%0d data=%0d want 0 0", ae, de); end
    n_checks++; if (resync_err_out !== 1'b0) begin n_fail++; $display("FAIL pre_resync_flag got %0h want 0", resync_err_out); end
    for (int i = 0; i < 76800; i++) begin
      if (i == 0) thresh_2_in = 8'd50;
      if (i == 2000) thresh_2_in = 8'd250;
      pix(i, i < 1000 ? 8'd128 : 8'd100);
      tick;
      ed = i < 1000 ? 4'b0111 : (i < 2000 || LATCH) ? 4'b0011 : 4'b0001;
      if (we_out === 1'b1) wc++;
      if (we_out !== 1'b1 || addr_out !== 17'(i)) ae++;
      if (data_out !== ed) de++;
      if (frame_done_out === 1'b1) begin dc++; da = addr_out; end
      if (i == 0) begin
        n_checks++; if (resync_err_out !== 1'b1 || addr_out !== 17'd0) begin n_fail++; $display("FAIL resync_first got flag=%0h addr=%0d want 1 0", resync_err_out, addr_out); end
      end
    end
    pixel_valid_in = 1'b0;
    n_checks++; if (wc !== 76800) begin n_fail++; $display("FAIL frame_writes got %0d want 76800", wc); end
    n_checks++; if (ae !== 0) begin n_fail++; $display("FAIL frame_addr_errs got %0d want 0", ae); end
    n_checks++; if (de !== 0) begin n_fail++; $display("FAIL frame_data_errs got %0d want 0", de); end
    n_checks++; if (dc !== 1 || da !== 17'd76799) begin n_fail++; $display("FAIL frame_done got count=%0d addr=%0d want 1 76799", dc, da); end
    n_checks++; if (resync_err_out !== 1'b1) begin n_fail++; $display("FAIL resync_sticky got %0h want 1", resync_err_out); end
    pix(7, 8'd255);
    tick;
    n_checks++; if (busy_out !== 1'b1 || we_out !== 1'b0 || frame_done_out !== 1'b0) begin n_fail++; $display("FAIL continuous_rewait got busy=%0h we=%0h done=%0h want 1 0 0", busy_out, we_out, frame_done_out); end
    ae = 0; de = 0;
    for (int i = 0; i < 100; i++) begin
      arm_in = (i == 50);
      pix(i, 8'd128);
      tick;
      if (we_out !== 1'b1 || addr_out !== 17'(i)) ae++;
      if (data_out !== (LATCH ? 4'b0101 : 4'b0101)) de++;
    end
    arm_in = 1'b0;
    pixel_valid_in = 1'b0;
    n_checks++; if (ae !== 0 || de !== 0) begin n_fail++; $display("FAIL second_frame_errs got addr=%0d data=%0d want 0 0", ae, de); end
    n_checks++; if (resync_err_out !== 1'b1) begin n_fail++; $display("FAIL arm_ignored_in_write got resync=%0h want 1", resync_err_out); end
  endtask

  task automatic test_reset_midframe;
    int ae = 0, wc = 0;
    rst_in = 1'b1;
    tick;
    rst_in = 1'b0;
    continuous_in = 1'b0;
    n_checks++; if (resync_err_out !== 1'b0) begin n_fail++; $display("FAIL reset_clears_resync got %0h want 0", resync_err_out); end
    arm;
    for (int i = 0; i < 1000; i++) begin
      pix(i, 8'd128);
      tick;
      if (we_out !== 1'b1 || addr_out !== 17'(i)) ae++;
    end
    n_checks++; if (ae !== 0) begin n_fail++; $display("FAIL pre_reset_addr_errs got %0d want 0", ae); end
    pix(1000, 8'd255);
    rst_in = 1'b1;
    tick;
    rst_in = 1'b0;
    n_checks++; if ({we_out, addr_out, data_out, busy_out, frame_done_out, resync_err_out} !== 25'd0) begin n_fail++; $display("FAIL midframe_reset_outputs got we=%0h addr=%0d data=%0h busy=%0h done=%0h resync=%0h want all 0", we_out, addr_out, data_out, busy_out, frame_done_out, resync_err_out); end
    for (int i = 0; i < 4; i++) begin
      pix(i, 8'd255);
      tick;
      if (we_out === 1'b1) wc++;
    end
    n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL no_write_without_arm got %0d want 0", wc); end
    arm;
    pix(3, 8'd255);
    tick;
    n_checks++; if (we_out !== 1'b0) begin n_fail++; $display("FAIL rearm_wait_sof got we=%0h want 0", we_out); end
    pix(0, 8'd255);
    tick;
    n_checks++; if (we_out !== 1'b1 || addr_out !== 17'd0 || data_out !== 4'b1111) begin n_fail++; $display("FAIL rearm_sof_write got we=%0h addr=%0d data=%0h want 1 0 f", we_out, addr_out, data_out); end
    pixel_valid_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; arm_in = 1'b0; continuous_in = 1'b0; pixel_valid_in = 1'b0;
    hcount_in = '0; vcount_in = '0; pixel_in = '0;
    thresh_1_in = '0; thresh_2_in = '0; thresh_3_in = '0; thresh_4_in = '0;
    test_reset;
    test_valid_gaps;
    test_frame_resync_continuous;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
